// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV64 integer datapath.
//   XLEN / REG_AW : default data width and register-address width
//   X0            : architectural zero register index
//   wb_sel_e      : writeback source encoding (ALU result vs load data)
//   *_LSB         : bit positions of rs1 / rs2 / rd inside an instruction word
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

endpackage

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
// One combinational read port of the integer register file.
//   rd_addr : register being read
//   wb_en   : writeback strobe this cycle
//   wb_addr : writeback destination this cycle
//   wv      : writeback value this cycle (already source-muxed)
//   reg_q   : stored value of register rd_addr
//   busy_q  : scoreboard bit of register rd_addr
//   rd_data : x0 -> 0, else bypassed writeback value, else stored value
//   rd_busy : pending write not being retired this cycle
// ---------------------------------------------------------------------------
module regfile_rdport #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   rd_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wv,
  input  logic [XLEN-1:0] reg_q,
  input  logic            busy_q,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  import rv_pkg::*;

  logic bypass;

  // A writeback landing on the register we read this cycle is forwarded so
  // the consumer sees the value without waiting for the storage update. The
  // same match also hides the busy bit, because the producer is retiring now.
  // x0 is checked first so a (dropped) write to x0 can never leak through.
  always_comb begin
    bypass  = wb_en && (wb_addr == rd_addr);
    rd_data = reg_q;
    if (rd_addr == AW'(X0)) begin
      rd_data = '0;
    end else if (bypass) begin
      rd_data = wv;
    end
    rd_busy = busy_q & ~bypass;
  end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Parametrised integer register file with NRD read ports, internal writeback
// source mux, x0 hardwired to zero, write-to-read bypass and a pending-write
// scoreboard that lets decode stall on load-use hazards.
//   clk, rst_n         : clock, synchronous active-low reset
//   rd_en/rd_addr      : per-port read valid and address (packed, AW per port)
//   rd_data/rd_busy    : per-port data (packed, XLEN per port) and busy flag
//   stall              : some enabled port reads a register still pending
//   wb_en/wb_addr      : writeback strobe and destination
//   wb_sel/wb_alu/wb_mem : writeback source select and the two candidates
//   sb_set/sb_addr     : mark a register as pending (long-latency producer)
//   pending_cnt        : number of registers currently pending
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int AW    = rv_pkg::REG_AW,
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  output logic              stall,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic              wb_sel,
  input  logic [XLEN-1:0]   wb_alu,
  input  logic [XLEN-1:0]   wb_mem,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  output logic [AW:0]       pending_cnt
);

  import rv_pkg::*;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;
  logic [XLEN-1:0]  wv;
  logic             wb_live;

  assign wv      = (wb_sel == WB_MEM) ? wb_mem : wb_alu;
  assign wb_live = wb_en && (wb_addr != AW'(X0));

  // Architectural storage. Reset clears every register; afterwards only
  // non-x0 destinations are written, so regs[0] stays zero for good.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_addr] <= wv;
    end
  end

  // Scoreboard next state. Issuing a new producer beats the retirement of an
  // older one to the same register, otherwise the new producer's result
  // would be treated as already available. x0 is never tracked. The popcount
  // of the next state feeds the counter so it moves in lockstep with busy.
  always_comb begin
    busy_next    = busy;
    busy_next[0] = 1'b0;
    cnt_next     = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (sb_set && (sb_addr == AW'(i))) begin
        busy_next[i] = 1'b1;
      end else if (wb_en && (wb_addr == AW'(i))) begin
        busy_next[i] = 1'b0;
      end
    end
    for (int i = 1; i < NREGS; i++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
    end
  end

  // Scoreboard and pending counter registers. Reset wipes any in-flight
  // producers, which matches the pipeline being flushed at the same time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_next;
      pending_cnt <= cnt_next;
    end
  end

  // One read port per lane; each looks up its own storage word and busy bit.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr_k;
    assign addr_k = rd_addr[k*AW +: AW];

    regfile_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .rd_addr(addr_k),
      .wb_en  (wb_en),
      .wb_addr(wb_addr),
      .wv     (wv),
      .reg_q  (regs[addr_k]),
      .busy_q (busy[addr_k]),
      .rd_data(rd_data[k*XLEN +: XLEN]),
      .rd_busy(rd_busy[k])
    );
  end

  assign stall = |(rd_busy & rd_en);

endmodule
